// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty control sequencer.
// BITTY_ILLEGAL_TRAP_EN adds the TRAP state for reserved opcodes.
package bitty_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;

    localparam logic [3:0] IMM_SEL = 4'd8;
    localparam logic [3:0] RES_SEL = 4'd9;

    localparam logic [1:0] FMT_RR  = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR  = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam int FMT_LSB = 0;
    localparam int ALU_LSB = 2;
    localparam int IMM_LSB = 5;
    localparam int RY_LSB  = 10;
    localparam int RX_LSB  = 13;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        LOAD_S,
        EXEC,
        WB,
        BRANCH,
        NOP
`ifdef BITTY_ILLEGAL_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [2:0] idx
    );
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/bitty_control_fsm_if.sv
// Control bus between the bitty sequencer and its datapath.
// master = sequencer side, slave = fetch/datapath side.
interface bitty_control_fsm_if;
    import bitty_pkg::*;

    logic                run;
    logic [DATA_W-1:0]   instruction;
    logic                en_pc;
    logic                en_s;
    logic                en_c;
    logic [3:0]          mux_sel;
    logic [2:0]          alu_sel;
    logic [DATA_W-1:0]   imm;
    logic [NUM_REGS-1:0] reg_we;
    logic                done;
    logic                illegal;

    modport master (
        input  run, instruction,
        output en_pc, en_s, en_c, mux_sel, alu_sel,
        output imm, reg_we, done, illegal
    );

    modport slave (
        output run, instruction,
        input  en_pc, en_s, en_c, mux_sel, alu_sel,
        input  imm, reg_we, done, illegal
    );

endinterface

// File: rtl/bitty_decoder.sv
// Pure field extraction from a latched bitty instruction word.
// Immediate is the zero-extended 8-bit field [12:5].
module bitty_decoder
    import bitty_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [1:0]        fmt,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] imm
);

    assign fmt     = instr[FMT_LSB +: 2];
    assign alu_sel = instr[ALU_LSB +: 3];
    assign rx      = instr[RX_LSB +: 3];
    assign ry      = instr[RY_LSB +: 3];
    assign imm     = DATA_W'(instr[IMM_LSB +: 8]);

endmodule

// File: rtl/bitty_control_fsm.sv
// Multi-cycle bitty control sequencer with registered Moore outputs.
// Define BITTY_ILLEGAL_TRAP_EN to trap on reserved opcodes.
module bitty_control_fsm
    import bitty_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    bitty_control_fsm_if.master bus
);

    state_t              state;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   dec_in;
    logic [1:0]          fmt;
    logic [2:0]          rx;
    logic [2:0]          ry;
    logic [2:0]          dec_alu;
    logic [DATA_W-1:0]   dec_imm;

    logic                en_pc;
    logic                en_s;
    logic                en_c;
    logic                done;
    logic [3:0]          mux_sel;
    logic [2:0]          alu_sel;
    logic [DATA_W-1:0]   imm;
    logic [NUM_REGS-1:0] reg_we;

    // In DECODE the word is being latched, so decode it directly;
    // afterwards the latched copy is identical.
    assign dec_in = (state == DECODE) ? bus.instruction : ir;

    bitty_decoder u_dec (
        .instr   (dec_in),
        .fmt     (fmt),
        .rx      (rx),
        .ry      (ry),
        .alu_sel (dec_alu),
        .imm     (dec_imm)
    );

    assign bus.en_pc   = en_pc;
    assign bus.en_s    = en_s;
    assign bus.en_c    = en_c;
    assign bus.done    = done;
    assign bus.mux_sel = mux_sel;
    assign bus.alu_sel = alu_sel;
    assign bus.imm     = imm;
    assign bus.reg_we  = reg_we;

`ifdef BITTY_ILLEGAL_TRAP_EN
    logic illegal;

    assign bus.illegal = illegal;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            illegal <= 1'b0;
        else if (state == DECODE && fmt == FMT_RSV)
            illegal <= 1'b1;
    end
`else
    assign bus.illegal = 1'b0;
`endif

    // Sequencer: outputs are set on entry to the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ir      <= '0;
            en_pc   <= 1'b0;
            en_s    <= 1'b0;
            en_c    <= 1'b0;
            done    <= 1'b0;
            mux_sel <= '0;
            alu_sel <= '0;
            imm     <= '0;
            reg_we  <= '0;
        end else begin
            en_pc   <= 1'b0;
            en_s    <= 1'b0;
            en_c    <= 1'b0;
            done    <= 1'b0;
            mux_sel <= '0;
            reg_we  <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.run)
                        state <= FETCH;
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir <= bus.instruction;
                    unique case (fmt)
                        FMT_RR, FMT_IMM: begin
                            state   <= LOAD_S;
                            mux_sel <= {1'b0, rx};
                            en_s    <= 1'b1;
                            alu_sel <= dec_alu;
                            imm     <= (fmt == FMT_IMM) ? dec_imm : '0;
                        end
                        FMT_BR: begin
                            state <= BRANCH;
                            en_pc <= 1'b1;
                            done  <= 1'b1;
                        end
                        FMT_RSV: begin
`ifdef BITTY_ILLEGAL_TRAP_EN
                            state <= TRAP;
                            done  <= 1'b1;
`else
                            state <= NOP;
                            en_pc <= 1'b1;
                            done  <= 1'b1;
`endif
                        end
                    endcase
                end
                LOAD_S: begin
                    state   <= EXEC;
                    mux_sel <= (fmt == FMT_IMM) ? IMM_SEL : {1'b0, ry};
                    en_c    <= 1'b1;
                end
                EXEC: begin
                    state   <= WB;
                    mux_sel <= RES_SEL;
                    reg_we  <= reg_onehot(rx);
                    en_pc   <= 1'b1;
                    done    <= 1'b1;
                end
                WB, BRANCH, NOP: begin
                    alu_sel <= '0;
                    imm     <= '0;
                    state   <= bus.run ? FETCH : IDLE;
                end
`ifdef BITTY_ILLEGAL_TRAP_EN
                TRAP: begin
                    state <= TRAP;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
